// File: rtl/ajuste_reloj_ctrl.sv
// Run/set controller for a 12-hour H:MM clock: per-minute advance pulses and a two-button set flow.
// Optional build macro AJUSTE_TIMEOUT_EN aborts an idle edit after TIMEOUT_SEG seconds.
`timescale 1ns/1ps
module ajuste_reloj_ctrl #(
  parameter int SEG_POR_MIN = 60,
  parameter int TIMEOUT_SEG = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_seg,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic [3:0] hora_act,
  input  logic [3:0] dmin_act,
  input  logic [3:0] umin_act,
  output logic       min_tick,
  output logic       ajuste,
  output logic [3:0] ajust_hora,
  output logic [3:0] ajust_dmin,
  output logic [3:0] ajust_umin,
  output logic [1:0] campo,
  output logic       parpadeo
);

  typedef enum logic [2:0] {RUN, SET_HORA, SET_DMIN, SET_UMIN, LOAD} state_t;

  state_t     state_q, state_d;
  logic [5:0] seg_q, seg_d;
  logic [3:0] hora_q, hora_d, dmin_q, dmin_d, umin_q, umin_d;
  logic       min_tick_q, min_tick_d, ajuste_q, ajuste_d, parpadeo_q, parpadeo_d;
  logic [1:0] campo_q, campo_d;
  logic       en_edicion;

  assign en_edicion = (state_q == SET_HORA) || (state_q == SET_DMIN) || (state_q == SET_UMIN);

`ifdef AJUSTE_TIMEOUT_EN
  logic [5:0] idle_q, idle_d;
  logic       abortar;

  always_comb begin
    idle_d  = 6'd0;
    abortar = 1'b0;
    if (en_edicion && !btn_modo && !btn_inc) begin
      idle_d = idle_q;
      if (tick_seg) begin
        if (idle_q == 6'(TIMEOUT_SEG - 1)) begin
          abortar = 1'b1;
          idle_d  = 6'd0;
        end else begin
          idle_d = idle_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) idle_q <= 6'd0;
    else       idle_q <= idle_d;
  end
`else
  logic abortar;
  logic unused_timeout;
  assign abortar        = 1'b0;
  assign unused_timeout = ^6'(TIMEOUT_SEG);
`endif

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    hora_d     = hora_q;
    dmin_d     = dmin_q;
    umin_d     = umin_q;
    min_tick_d = 1'b0;
    case (state_q)
      RUN: begin
        if (btn_modo) begin
          hora_d  = (hora_act >= 4'd1 && hora_act <= 4'd12) ? hora_act : 4'd1;
          dmin_d  = (dmin_act > 4'd5) ? 4'd0 : dmin_act;
          umin_d  = (umin_act > 4'd9) ? 4'd0 : umin_act;
          seg_d   = 6'd0;
          state_d = SET_HORA;
        end else if (tick_seg) begin
          if (seg_q == 6'(SEG_POR_MIN - 1)) begin
            seg_d      = 6'd0;
            min_tick_d = 1'b1;
          end else begin
            seg_d = seg_q + 6'd1;
          end
        end
      end
      SET_HORA: begin
        seg_d = 6'd0;
        if (btn_modo)     state_d = SET_DMIN;
        else if (btn_inc) hora_d  = (hora_q >= 4'd12) ? 4'd1 : hora_q + 4'd1;
      end
      SET_DMIN: begin
        seg_d = 6'd0;
        if (btn_modo)     state_d = SET_UMIN;
        else if (btn_inc) dmin_d  = (dmin_q >= 4'd5) ? 4'd0 : dmin_q + 4'd1;
      end
      SET_UMIN: begin
        seg_d = 6'd0;
        if (btn_modo)     state_d = LOAD;
        else if (btn_inc) umin_d  = (umin_q >= 4'd9) ? 4'd0 : umin_q + 4'd1;
      end
      LOAD: begin
        seg_d   = 6'd0;
        state_d = RUN;
      end
      default: begin
        seg_d   = 6'd0;
        state_d = RUN;
      end
    endcase
    if (abortar) state_d = RUN;

    // Outputs are registered from the next state so they line up with state_q.
    ajuste_d   = (state_d == LOAD);
    parpadeo_d = 1'b0;
    campo_d    = 2'd0;
    case (state_d)
      SET_HORA: campo_d = 2'd1;
      SET_DMIN: campo_d = 2'd2;
      SET_UMIN: campo_d = 2'd3;
      default:  campo_d = 2'd0;
    endcase
    if (campo_d != 2'd0) begin
      if (state_q == RUN) parpadeo_d = 1'b1;
      else if (tick_seg)  parpadeo_d = ~parpadeo_q;
      else                parpadeo_d = parpadeo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      seg_q      <= 6'd0;
      hora_q     <= 4'd1;
      dmin_q     <= 4'd0;
      umin_q     <= 4'd0;
      min_tick_q <= 1'b0;
      ajuste_q   <= 1'b0;
      campo_q    <= 2'd0;
      parpadeo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      hora_q     <= hora_d;
      dmin_q     <= dmin_d;
      umin_q     <= umin_d;
      min_tick_q <= min_tick_d;
      ajuste_q   <= ajuste_d;
      campo_q    <= campo_d;
      parpadeo_q <= parpadeo_d;
    end
  end

  assign min_tick   = min_tick_q;
  assign ajuste     = ajuste_q;
  assign ajust_hora = hora_q;
  assign ajust_dmin = dmin_q;
  assign ajust_umin = umin_q;
  assign campo      = campo_q;
  assign parpadeo   = parpadeo_q;

endmodule
